// File: rtl/swerv_trace_unpacker.sv
// Trace-port consumer: compacts up to three retired-instruction slots per cycle
// into a record FIFO and drains it one record per cycle over a valid/ready stream.
module swerv_trace_unpacker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trace_en,
  input  logic [2:0]       trace_rv_i_valid_ip,
  input  logic [95:0]      trace_rv_i_insn_ip,
  input  logic [95:0]      trace_rv_i_address_ip,
  input  logic [2:0]       trace_rv_i_exception_ip,
  input  logic [4:0]       trace_rv_i_ecause_ip,
  input  logic [2:0]       trace_rv_i_interrupt_ip,
  input  logic [31:0]      trace_rv_i_tval_ip,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_slot,
  output logic [31:0]      out_insn,
  output logic [31:0]      out_addr,
  output logic             out_exc,
  output logic             out_intr,
  output logic [4:0]       out_ecause,
  output logic [31:0]      out_tval,
  output logic [AW:0]      fifo_count,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef struct packed {
    logic [1:0]  slot;
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } rec_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  rec_t           mem [DEPTH];
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic           overflow_r;
  logic [CNT_W-1:0] drop_cnt_r;

  rec_t           rec_s [3];
  logic [AW-1:0]  widx_s [3];
  logic [1:0]     n_s;
  logic [AW:0]    count_s;
  logic [AW:0]    free_s;
  logic           group_s;
  logic           accept_s;
  logic           drop_s;
  logic           pop_s;
  logic [AW:0]    acc_n_s;
  rec_t           head_s;

  // Build per-slot records and their compacted write addresses; trap info only travels with a trap.
  always_comb begin
    n_s = popcount3(trace_rv_i_valid_ip);
    for (int k = 0; k < 3; k++) begin
      rec_s[k].slot = 2'(k);
      rec_s[k].insn = trace_rv_i_insn_ip[32*k +: 32];
      rec_s[k].addr = trace_rv_i_address_ip[32*k +: 32];
      rec_s[k].exc  = trace_rv_i_exception_ip[k];
      rec_s[k].intr = trace_rv_i_interrupt_ip[k];
      if (trace_rv_i_exception_ip[k] || trace_rv_i_interrupt_ip[k]) begin
        rec_s[k].ecause = trace_rv_i_ecause_ip;
        rec_s[k].tval   = trace_rv_i_tval_ip;
      end else begin
        rec_s[k].ecause = 5'd0;
        rec_s[k].tval   = 32'd0;
      end
    end
    widx_s[0] = wr_ptr_r[AW-1:0];
    widx_s[1] = wr_ptr_r[AW-1:0] + AW'(trace_rv_i_valid_ip[0]);
    widx_s[2] = wr_ptr_r[AW-1:0] + AW'(trace_rv_i_valid_ip[0]) + AW'(trace_rv_i_valid_ip[1]);
  end

  // Space check uses the registered occupancy only; a same-cycle pop never makes room.
  always_comb begin
    count_s  = wr_ptr_r - rd_ptr_r;
    free_s   = (AW+1)'(DEPTH) - count_s;
    group_s  = trace_en && (trace_rv_i_valid_ip != 3'b000);
    accept_s = group_s && ((AW+1)'(n_s) <= free_s);
    drop_s   = group_s && !accept_s;
    pop_s    = (count_s != {(AW+1){1'b0}}) && out_ready;
    if (accept_s) begin
      acc_n_s = (AW+1)'(n_s);
    end else begin
      acc_n_s = {(AW+1){1'b0}};
    end
  end

  // Pointers and drop bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {(AW+1){1'b0}};
      rd_ptr_r   <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + acc_n_s;
      rd_ptr_r <= rd_ptr_r + (AW+1)'(pop_s);
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  // Record storage; content is masked at the output whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (accept_s && trace_rv_i_valid_ip[k]) begin
        mem[widx_s[k]] <= rec_s[k];
      end
    end
  end

  // Present the stored head record, zero when nothing is queued.
  always_comb begin
    head_s     = mem[rd_ptr_r[AW-1:0]];
    out_valid  = (count_s != {(AW+1){1'b0}});
    fifo_count = count_s;
    overflow   = overflow_r;
    drop_cnt   = drop_cnt_r;
    if (out_valid) begin
      out_slot   = head_s.slot;
      out_insn   = head_s.insn;
      out_addr   = head_s.addr;
      out_exc    = head_s.exc;
      out_intr   = head_s.intr;
      out_ecause = head_s.ecause;
      out_tval   = head_s.tval;
    end else begin
      out_slot   = 2'd0;
      out_insn   = 32'd0;
      out_addr   = 32'd0;
      out_exc    = 1'b0;
      out_intr   = 1'b0;
      out_ecause = 5'd0;
      out_tval   = 32'd0;
    end
  end

endmodule

// File: tb/tb_swerv_trace_unpacker.sv
// Self-checking bench for swerv_trace_unpacker: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_swerv_trace_unpacker;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en;
  logic [2:0]  valid_ip;
  logic [95:0] insn_ip;
  logic [95:0] addr_ip;
  logic [2:0]  exc_ip;
  logic [4:0]  ecause_ip;
  logic [2:0]  intr_ip;
  logic [31:0] tval_ip;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_slot;
  logic [31:0] out_insn;
  logic [31:0] out_addr;
  logic        out_exc;
  logic        out_intr;
  logic [4:0]  out_ecause;
  logic [31:0] out_tval;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  swerv_trace_unpacker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .trace_rv_i_valid_ip(valid_ip), .trace_rv_i_insn_ip(insn_ip),
    .trace_rv_i_address_ip(addr_ip), .trace_rv_i_exception_ip(exc_ip),
    .trace_rv_i_ecause_ip(ecause_ip), .trace_rv_i_interrupt_ip(intr_ip),
    .trace_rv_i_tval_ip(tval_ip),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot(out_slot),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval), .fifo_count(fifo_count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [1:0]  slot;
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
  } mrec_t;

  typedef struct {
    logic        en;
    logic [2:0]  valid;
    logic [95:0] insn;
    logic [95:0] addr;
    logic [2:0]  exc;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        ready;
    logic        e_valid;
    logic [1:0]  e_slot;
    logic [31:0] e_insn;
    logic [31:0] e_addr;
    logic        e_exc;
    logic [4:0]  e_ecause;
    logic [31:0] e_tval;
    logic [3:0]  e_count;
  } vec_t;

  mrec_t q[$];
  int    m_drop;
  bit    m_ovf;
  int    vectors;
  int    miscompares;
  bit    collect;
  logic [31:0] got[$];
  logic [31:0] sent[$];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    mrec_t h;
    cmp("out_valid", 64'(out_valid), 64'(q.size() != 0));
    cmp("fifo_count", 64'(fifo_count), 64'(q.size()));
    cmp("overflow", 64'(overflow), 64'(m_ovf));
    cmp("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (q.size() != 0) begin
      h = q[0];
      cmp("head_slot_insn", {30'd0, out_slot, out_insn}, {30'd0, h.slot, h.insn});
      cmp("head_addr", 64'(out_addr), 64'(h.addr));
      cmp("head_flags", {25'd0, out_exc, out_intr, out_ecause, out_tval},
          {25'd0, h.exc, h.intr, h.ecause, h.tval});
    end else begin
      cmp("idle_data", {out_insn, out_addr}, 64'd0);
      cmp("idle_misc", {25'd0, out_slot, out_exc, out_intr, out_ecause, out_tval}, 64'd0);
    end
  endtask

  // One clock: the model applies the rules to the inputs held across the edge.
  task automatic tick();
    mrec_t nr[$];
    mrec_t r;
    int    n;
    int    free;
    bit    pop;
    pop  = (q.size() != 0) && out_ready;
    free = DEPTH - q.size();
    n    = trace_en ? $countones(valid_ip) : 0;
    for (int k = 0; k < 3; k++) begin
      if (trace_en && valid_ip[k]) begin
        r.slot   = 2'(k);
        r.insn   = insn_ip[32*k +: 32];
        r.addr   = addr_ip[32*k +: 32];
        r.exc    = exc_ip[k];
        r.intr   = intr_ip[k];
        r.ecause = (exc_ip[k] || intr_ip[k]) ? ecause_ip : 5'd0;
        r.tval   = (exc_ip[k] || intr_ip[k]) ? tval_ip : 32'd0;
        nr.push_back(r);
      end
    end
    if (collect && out_valid && out_ready) got.push_back(out_insn);
    if (collect && n > 0 && n <= free) begin
      foreach (nr[i]) sent.push_back(nr[i].insn);
    end
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (n > 0) begin
      if (n <= free) begin
        foreach (nr[i]) q.push_back(nr[i]);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    check_model();
  endtask

  task automatic drive(input logic en, input logic [2:0] v, input logic rdy);
    trace_en  = en;
    valid_ip  = v;
    out_ready = rdy;
    insn_ip   = {$urandom, $urandom, $urandom};
    addr_ip   = {$urandom, $urandom, $urandom};
    exc_ip    = 3'($urandom_range(0, 7));
    intr_ip   = 3'($urandom_range(0, 7));
    ecause_ip = 5'($urandom_range(0, 31));
    tval_ip   = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(1'b0, 3'b000, 1'b1);
      tick();
    end
  endtask

  vec_t tbl[6];
  logic [31:0] g1_insn;

  initial begin
    vectors = 0; miscompares = 0; m_drop = 0; m_ovf = 1'b0; collect = 1'b0;
    rst = 1'b1;
    drive(1'b0, 3'b000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", {59'd0, out_valid, fifo_count}, 64'd0);
    cmp("reset_ovf_drop", {47'd0, overflow, drop_cnt}, 64'd0);
    rst = 1'b0;

    tbl[0] = '{1'b1, 3'b101, {32'hAAAA0002, 32'hBBBB0001, 32'hCCCC0000},
               {32'h00001008, 32'h00001004, 32'h00001000}, 3'b000, 5'd0, 32'd0, 1'b1,
               1'b1, 2'd0, 32'hCCCC0000, 32'h00001000, 1'b0, 5'd0, 32'd0, 4'd2};
    tbl[1] = '{1'b0, 3'b000, 96'd0, 96'd0, 3'b000, 5'd0, 32'd0, 1'b1,
               1'b1, 2'd2, 32'hAAAA0002, 32'h00001008, 1'b0, 5'd0, 32'd0, 4'd1};
    tbl[2] = '{1'b0, 3'b000, 96'd0, 96'd0, 3'b000, 5'd0, 32'd0, 1'b1,
               1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd0};
    tbl[3] = '{1'b1, 3'b010, {32'd0, 32'h12345678, 32'd0}, {32'd0, 32'h00002004, 32'd0},
               3'b010, 5'd2, 32'hDEADBEEF, 1'b1,
               1'b1, 2'd1, 32'h12345678, 32'h00002004, 1'b1, 5'd2, 32'hDEADBEEF, 4'd1};
    tbl[4] = '{1'b1, 3'b010, {32'd0, 32'h9ABCDEF0, 32'd0}, {32'd0, 32'h00002008, 32'd0},
               3'b000, 5'd2, 32'hDEADBEEF, 1'b1,
               1'b1, 2'd1, 32'h9ABCDEF0, 32'h00002008, 1'b0, 5'd0, 32'd0, 4'd1};
    tbl[5] = '{1'b0, 3'b000, 96'd0, 96'd0, 3'b000, 5'd0, 32'd0, 1'b1,
               1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 4'd0};

    for (int i = 0; i < 6; i++) begin
      trace_en = tbl[i].en; valid_ip = tbl[i].valid; insn_ip = tbl[i].insn;
      addr_ip = tbl[i].addr; exc_ip = tbl[i].exc; intr_ip = 3'b000;
      ecause_ip = tbl[i].ecause; tval_ip = tbl[i].tval; out_ready = tbl[i].ready;
      tick();
      cmp("tbl_valid_count", {59'd0, out_valid, fifo_count}, {59'd0, tbl[i].e_valid, tbl[i].e_count});
      cmp("tbl_slot_insn", {30'd0, out_slot, out_insn}, {30'd0, tbl[i].e_slot, tbl[i].e_insn});
      cmp("tbl_addr", 64'(out_addr), 64'(tbl[i].e_addr));
      cmp("tbl_trap", {26'd0, out_exc, out_ecause, out_tval},
          {26'd0, tbl[i].e_exc, tbl[i].e_ecause, tbl[i].e_tval});
    end

    // Stream of 40 single-slot groups with toggling ready, wrapping the pointers.
    collect = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i % 2 == 0) drive(1'b1, 3'b001 << $urandom_range(0, 2), 1'b1);
      else            drive(1'b0, 3'b000, 1'b0);
      tick();
    end
    drain();
    collect = 1'b0;
    cmp("stream_sent", 64'(sent.size()), 64'd40);
    cmp("stream_len", 64'(got.size()), 64'd40);
    for (int i = 0; i < got.size() && i < sent.size(); i++) cmp("stream_order", 64'(got[i]), 64'(sent[i]));
    cmp("stream_no_drop", 64'(drop_cnt), 64'd0);

    // Fill to DEPTH with 3+3+2, then a single-record group must drop.
    drive(1'b1, 3'b111, 1'b0); g1_insn = insn_ip[31:0]; tick();
    drive(1'b1, 3'b111, 1'b0); tick();
    drive(1'b1, 3'b011, 1'b0); tick();
    drive(1'b1, 3'b001, 1'b0); tick();
    cmp("full_count", 64'(fifo_count), 64'd8);
    cmp("full_ovf_drop", {47'd0, overflow, drop_cnt}, {47'd0, 1'b1, 16'd1});
    cmp("full_hold", {30'd0, out_slot, out_insn}, {32'd0, g1_insn});
    // Full with a simultaneous pop still drops.
    drive(1'b1, 3'b100, 1'b1); tick();
    cmp("full_pop_drop", {44'd0, fifo_count, drop_cnt}, {44'd0, 4'd7, 16'd2});
    drain();

    // count=7, push 2 while popping 1: dropped, count 6.
    drive(1'b1, 3'b111, 1'b0); tick();
    drive(1'b1, 3'b111, 1'b0); tick();
    drive(1'b1, 3'b010, 1'b0); tick();
    drive(1'b1, 3'b110, 1'b1); tick();
    cmp("seven_pop_drop", {44'd0, fifo_count, drop_cnt}, {44'd0, 4'd6, 16'd3});
    drain();

    // Asynchronous reset with 5 records queued.
    drive(1'b1, 3'b111, 1'b0); tick();
    drive(1'b1, 3'b101, 1'b0); tick();
    cmp("pre_reset_count", 64'(fifo_count), 64'd5);
    #2 rst = 1'b1;
    #1;
    cmp("async_reset", {58'd0, overflow, out_valid, fifo_count}, 64'd0);
    q.delete(); m_ovf = 1'b0; m_drop = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 3'b001, 1'b0); tick();
    cmp("post_reset_push", {59'd0, out_valid, fifo_count}, {59'd0, 1'b1, 4'd1});
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/swerv_trace_unpacker.md
Name: swerv_trace_unpacker

Overview:
Consumer end of the core's trace port. Captures the per-cycle retirement trace bundle, which carries up to 3 instruction slots, and buffers each valid slot as one record in a FIFO. It drains the FIFO one record per cycle over a valid/ready stream toward a trace sink such as a UART/JTAG trace dumper or a debug bus. It sits in the SoC wrapper beside the core complex and is purely observational: it never back-pressures the core.

Parameters:
DEPTH, 8, FIFO depth in records; power of two, minimum 4.
CNT_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
trace_en  in  1  capture enable; when low, the trace inputs are ignored
trace_rv_i_valid_ip  in  3  per-slot retire valid (bit k = slot k)
trace_rv_i_insn_ip  in  96  slot k instruction at bits [32k+31:32k]
trace_rv_i_address_ip  in  96  slot k PC at bits [32k+31:32k]
trace_rv_i_exception_ip  in  3  per-slot exception flag
trace_rv_i_ecause_ip  in  5  cause, shared by all slots
trace_rv_i_interrupt_ip  in  3  per-slot interrupt flag
trace_rv_i_tval_ip  in  32  trap value, shared by all slots
out_valid  out  1  head record available
out_ready  in  1  sink accepts the head record
out_slot  out  2  originating slot index (0..2)
out_insn  out  32  instruction
out_addr  out  32  PC
out_exc  out  1  exception flag
out_intr  out  1  interrupt flag
out_ecause  out  5  cause; 0 unless out_exc or out_intr
out_tval  out  32  tval; 0 unless out_exc or out_intr
fifo_count  out  log2(DEPTH)+1  records currently stored
overflow  out  1  sticky; set on any dropped group
drop_cnt  out  CNT_W  number of dropped groups, saturating

Behaviour:
- Reset: asynchronous, active-high. All outputs and internal state go to 0: FIFO empty, pointers 0, overflow 0, drop_cnt 0. Output data fields read 0 while empty.
- Capture condition: a push group exists in a cycle when trace_en=1 and valid_ip != 0. The group size is n = popcount(valid_ip), from 1 to 3.
- Ordering: records are written in ascending slot order, so slot 0 goes before slot 1 before slot 2. Slots whose valid bit is 0 are skipped with no hole left in the FIFO.
- Record fields for slot k:
  - insn and addr come from slice k.
  - exc = exception_ip[k] and intr = interrupt_ip[k].
  - ecause and tval are copied only when exc or intr is set; otherwise they are zeroed.
- Space check: free = DEPTH - fifo_count, using the registered count. A pop in the same cycle does not add space.
- Acceptance: if n <= free, all n records are written in that cycle.
- Drop: if n > free, the whole group is dropped, with no partial write. On a drop, overflow is set and drop_cnt increments, saturating at all-ones.
- Latency: records written at edge N are visible on out_valid/out_* from cycle N+1. The output is the registered FIFO head; there is no combinational input-to-output path.
- Pop: on out_valid & out_ready, the head advances at the clock edge.
- Output hold: while out_valid=1 and out_ready=0, all out_* fields stay stable.
- Push and pop in the same cycle: count_next = count + n_accepted - pop.
  - The pop does not change the space check.
  - With count=DEPTH and a pop, a group with n>=1 is still dropped.
- Pointer wrap: rd/wr pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is count==DEPTH; empty is count==0.
- trace_en=0: no pushes happen and no drops are counted. Draining continues normally.
- Clearing overflow: overflow and drop_cnt clear only on reset.
- Reset mid-drain: contents are discarded and out_valid drops asynchronously.

Test Plan:
1. Reset, then one cycle with valid_ip=3'b101, insn={X,Y,Z}, addr={A2,A1,A0}, out_ready=1 -> the next cycle gives slot0 (insn Z, addr A0), then the cycle after gives slot2 (insn X, addr A2); fifo_count goes 2 then 1 then 0.
2. valid_ip=3'b010 with exception_ip=3'b010, ecause=5'd2, tval=32'hDEADBEEF -> record out_slot=1, out_exc=1, out_ecause=2, out_tval=DEADBEEF. Same ecause/tval with exception_ip=0 -> out_ecause=0, out_tval=0.
3. out_ready=0, DEPTH=8, push groups of 3, 3, 2, then 1 -> count reaches 8; the 1-record group is dropped; overflow=1, drop_cnt=1; out_* stay stable on slot0 of group 1.
4. count=7, push 2 records while popping 1 in the same cycle -> the group is dropped (free=1), drop_cnt increments, count becomes 6.
5. Stream 40 single-slot groups with out_ready toggling 1/0 -> all 40 records come out in order with no loss, exercising pointer wrap; drop_cnt=0.
6. Assert rst with 5 records queued -> out_valid=0 and fifo_count=0 immediately; after release, a new push is seen one cycle later.
